// File: rtl/vmem_fill_pkg.sv
// Shared constants and types for the video-memory rectangle-fill engine:
// register map, CTRL/STATUS bit positions and FSM state encoding.
package vmem_fill_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int COLOR_W_DEF = 3;

  localparam logic [1:0] REG_ORIGIN = 2'd0;
  localparam logic [1:0] REG_SIZE   = 2'd1;
  localparam logic [1:0] REG_COLOR  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL write bits
  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_OVR_CLR = 2;

  // STATUS read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// Bus bundle for the fill controller: config register port, CPU store port
// and the arbitrated video-memory write port.
interface vmem_fill_ctrl_if
  import vmem_fill_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
);

  logic                   cfg_we_i;
  logic [1:0]             cfg_addr_i;
  logic [31:0]            cfg_wdata_i;
  logic [31:0]            cfg_rdata_o;
  logic                   cpu_we_i;
  logic [2*COORD_W-1:0]   cpu_addr_i;
  logic [COLOR_W-1:0]     cpu_wdata_i;
  logic                   vmem_we_o;
  logic [2*COORD_W-1:0]   vmem_addr_o;
  logic [COLOR_W-1:0]     vmem_wdata_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cfg_rdata_o,
    input  vmem_we_o, vmem_addr_o, vmem_wdata_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cfg_rdata_o,
    output vmem_we_o, vmem_addr_o, vmem_wdata_o
  );

endinterface

// File: rtl/fill_rect_walker.sv
// Rectangle scan counters: x/y position plus column/row counts, loaded with a
// latched origin and size, advanced one pixel at a time in raster order.
module fill_rect_walker
  import vmem_fill_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] wm1_i,
  input  logic [COORD_W-1:0] hm1_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q, y_q, col_q, row_q;
  logic [COORD_W-1:0] x0_q, wm1_q, hm1_q;
  logic               rowEnd;

  assign rowEnd = (col_q == wm1_q);
  assign last_o = rowEnd && (row_q == hm1_q);
  assign x_o    = x_q;
  assign y_o    = y_q;

  // x and y wrap naturally at the coordinate width; no clipping to the panel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      x0_q  <= '0;
      wm1_q <= '0;
      hm1_q <= '0;
    end else if (load_i) begin
      x0_q  <= x0_i;
      wm1_q <= wm1_i;
      hm1_q <= hm1_i;
      x_q   <= x0_i;
      y_q   <= y0_i;
      col_q <= '0;
      row_q <= '0;
    end else if (advance_i) begin
      if (rowEnd) begin
        x_q   <= x0_q;
        y_q   <= y_q + COORD_W'(1);
        col_q <= '0;
        row_q <= row_q + COORD_W'(1);
      end else begin
        x_q   <= x_q + COORD_W'(1);
        col_q <= col_q + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and video-memory write arbiter: CPU stores win every
// cycle, the engine fills the remaining cycles with a constant colour.
module vmem_fill_ctrl
  import vmem_fill_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  vmem_fill_ctrl_if.slave bus,
  output logic            busy_o,
  output logic            done_o
);

  localparam int AW = 2 * COORD_W;

  fill_state_e        state_q, state_d;
  logic [AW-1:0]      origin_q, size_q;
  logic [COLOR_W-1:0] color_q, fillColor_q;
  logic               ovr_q, ovr_d;
  logic               busy_q, done_q;
  logic               vmemWe_q;
  logic [AW-1:0]      vmemAddr_q;
  logic [COLOR_W-1:0] vmemData_q;
  logic [31:0]        rdata_q, rdata_d;

  logic               ctrlWr, startReq, abortReq, ovrClrReq;
  logic               load, issue, lastPix;
  logic [COORD_W-1:0] walkX, walkY;
  logic               unusedWdata;

  assign unusedWdata = ^bus.cfg_wdata_i[31:AW];

  assign ctrlWr    = bus.cfg_we_i && (bus.cfg_addr_i == REG_CTRL);
  assign startReq  = ctrlWr && bus.cfg_wdata_i[CTRL_START];
  assign abortReq  = ctrlWr && bus.cfg_wdata_i[CTRL_ABORT];
  assign ovrClrReq = ctrlWr && bus.cfg_wdata_i[CTRL_OVR_CLR];

  fill_rect_walker #(.COORD_W(COORD_W)) u_walker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .advance_i (issue),
    .x0_i      (origin_q[COORD_W-1:0]),
    .y0_i      (origin_q[AW-1:COORD_W]),
    .wm1_i     (size_q[COORD_W-1:0]),
    .hm1_i     (size_q[AW-1:COORD_W]),
    .x_o       (walkX),
    .y_o       (walkY),
    .last_o    (lastPix)
  );

  // An abort in the same cycle as a start or an issue always wins
  always_comb begin
    load    = (state_q == ST_IDLE) && startReq && !abortReq;
    issue   = (state_q == ST_RUN) && !bus.cpu_we_i && !abortReq;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load) state_d = ST_RUN;
      ST_RUN: begin
        if (abortReq)             state_d = ST_IDLE;
        else if (issue && lastPix) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ovr_d = ovr_q;
    if (startReq && (state_q != ST_IDLE)) ovr_d = 1'b1;
    else if (ovrClrReq)                   ovr_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.cfg_addr_i)
      REG_ORIGIN: rdata_d = 32'(origin_q);
      REG_SIZE:   rdata_d = 32'(size_q);
      REG_COLOR:  rdata_d = 32'(color_q);
      REG_CTRL: begin
        rdata_d[STAT_BUSY] = busy_q;
        rdata_d[STAT_OVR]  = ovr_q;
      end
      default: rdata_d = '0;
    endcase
  end

  // Programmable registers stay writable during a fill; the walker and
  // fillColor_q hold the copies the running fill actually uses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      origin_q    <= '0;
      size_q      <= '0;
      color_q     <= '0;
      fillColor_q <= '0;
    end else begin
      if (bus.cfg_we_i && (bus.cfg_addr_i == REG_ORIGIN)) origin_q <= bus.cfg_wdata_i[AW-1:0];
      if (bus.cfg_we_i && (bus.cfg_addr_i == REG_SIZE))   size_q   <= bus.cfg_wdata_i[AW-1:0];
      if (bus.cfg_we_i && (bus.cfg_addr_i == REG_COLOR))  color_q  <= bus.cfg_wdata_i[COLOR_W-1:0];
      if (load) fillColor_q <= color_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vmemWe_q   <= 1'b0;
      vmemAddr_q <= '0;
      vmemData_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_q == ST_DONE);
      rdata_q <= rdata_d;
      if (bus.cpu_we_i) begin
        vmemWe_q   <= 1'b1;
        vmemAddr_q <= bus.cpu_addr_i;
        vmemData_q <= bus.cpu_wdata_i;
      end else if (issue) begin
        vmemWe_q   <= 1'b1;
        vmemAddr_q <= {walkY, walkX};
        vmemData_q <= fillColor_q;
      end else begin
        vmemWe_q   <= 1'b0;
      end
    end
  end

  assign bus.vmem_we_o    = vmemWe_q;
  assign bus.vmem_addr_o  = vmemAddr_q;
  assign bus.vmem_wdata_o = vmemData_q;
  assign bus.cfg_rdata_o  = rdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Randomised bench for vmem_fill_ctrl: expected write streams come from the
// rectangle's raster pixel list merged with the CPU stores of each cycle.
module tb_vmem_fill_ctrl;
  import vmem_fill_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        busy_o;
  logic        done_o;
  int          total;
  int          bad;
  logic        ovrModel;
  logic [15:0] originModel;

  vmem_fill_ctrl_if bus ();

  vmem_fill_ctrl dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = REG_CTRL;
    bus.cfg_wdata_i = '0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = a;
    bus.cfg_wdata_i = d;
    tick();
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = REG_CTRL;
    if (a == REG_ORIGIN) originModel = d[15:0];
    if (a == REG_CTRL && d[CTRL_OVR_CLR]) ovrModel = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.cfg_we_i   = 1'b0;
    bus.cfg_addr_i = a;
    tick();
    checkOutput(tag, bus.cfg_rdata_o, exp);
    bus.cfg_addr_i = REG_CTRL;
  endtask

  // One fill: program, start, then cycle-by-cycle compare against the model.
  task automatic applyStimulus(input logic [7:0] x0, input logic [7:0] y0,
                               input logic [7:0] wm1, input logic [7:0] hm1,
                               input logic [2:0] color, input int cpuMode,
                               input int cpuAt, input int abortAfter, input int midStartAt);
    logic [15:0] pixQ[$];
    int          n, pix, tail, engineSeen, limit;
    logic        active, expDone, justDone, engaged;
    logic        cpu, abt, ms, orgWr, clr, expWe;
    logic [15:0] ca, expAddr;
    logic [2:0]  cd, expData;
    logic [31:0] expRd;

    pixQ.delete();
    for (int r = 0; r <= int'(hm1); r++)
      for (int c = 0; c <= int'(wm1); c++)
        pixQ.push_back({8'(int'(y0) + r), 8'(int'(x0) + c)});
    n = pixQ.size();

    cfgWrite(REG_ORIGIN, {16'd0, y0, x0});
    cfgWrite(REG_SIZE, {16'd0, hm1, wm1});
    cfgWrite(REG_COLOR, {29'd0, color});

    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = REG_CTRL;
    bus.cfg_wdata_i = 32'd1;
    tick();
    checkOutput("startBusy", 32'(busy_o), 32'd1);
    checkOutput("startIdleWe", 32'(bus.vmem_we_o), 32'd0);

    active     = 1'b1;
    expDone    = 1'b0;
    pix        = 0;
    tail       = 0;
    engineSeen = 0;
    limit      = ((abortAfter > 0) ? abortAfter : n) * 4 + 40;

    for (int it = 0; it < limit && tail < 3; it++) begin
      cpu     = (cpuMode == 1) ? ($urandom_range(0, 3) == 0) : (cpuMode == 2 && it == cpuAt);
      ca      = (cpuMode == 2) ? 16'h0000 : 16'($urandom);
      cd      = (cpuMode == 2) ? 3'd2 : 3'($urandom);
      abt     = (abortAfter > 0) && active && (pix == abortAfter);
      ms      = (it == midStartAt);
      orgWr   = (midStartAt >= 0) && (it == midStartAt + 1);
      clr     = ms && ($urandom_range(0, 1) == 1);
      engaged = active || expDone;
      expRd   = orgWr ? {16'd0, originModel} : {30'd0, ovrModel, active};

      bus.cpu_we_i    = cpu;
      bus.cpu_addr_i  = ca;
      bus.cpu_wdata_i = cd;
      bus.cfg_we_i    = abt || ms || orgWr;
      bus.cfg_addr_i  = orgWr ? REG_ORIGIN : REG_CTRL;
      bus.cfg_wdata_i = orgWr ? $urandom : {29'd0, clr, abt, ms};
      tick();

      checkOutput("rdata", bus.cfg_rdata_o, expRd);
      expWe   = 1'b0;
      expAddr = '0;
      expData = '0;
      if (cpu) begin
        expWe   = 1'b1;
        expAddr = ca;
        expData = cd;
      end else if (active && !abt) begin
        expWe   = 1'b1;
        expAddr = pixQ[pix];
        expData = color;
        pix++;
      end
      checkOutput("vmemWe", 32'(bus.vmem_we_o), 32'(expWe));
      if (expWe) begin
        checkOutput("vmemAddr", 32'(bus.vmem_addr_o), 32'(expAddr));
        checkOutput("vmemData", 32'(bus.vmem_wdata_o), 32'(expData));
      end
      if (bus.vmem_we_o && !cpu) engineSeen++;

      justDone = 1'b0;
      if (abt) active = 1'b0;
      else if (active && pix == n) begin
        active   = 1'b0;
        justDone = 1'b1;
      end
      if (ms && engaged) ovrModel = 1'b1;
      else if (clr)      ovrModel = 1'b0;
      if (orgWr) originModel = bus.cfg_wdata_i[15:0];

      checkOutput("done", 32'(done_o), 32'(expDone));
      expDone = justDone;
      checkOutput("busy", 32'(busy_o), 32'(active));
      if (!active) tail++;
    end

    checkOutput("fillTimeout", 32'(active), 32'd0);
    checkOutput("engineWrites", 32'(engineSeen), 32'((abortAfter > 0) ? abortAfter : n));
    idleInputs();
  endtask

  initial begin
    logic [7:0] rx, ry, rw, rh;
    int         rn, rms;

    total       = 0;
    bad         = 0;
    ovrModel    = 1'b0;
    originModel = '0;
    rst_i       = 1'b1;
    idleInputs();
    tick();
    tick();
    checkOutput("rstWe", 32'(bus.vmem_we_o), 32'd0);
    checkOutput("rstAddr", 32'(bus.vmem_addr_o), 32'd0);
    checkOutput("rstData", 32'(bus.vmem_wdata_o), 32'd0);
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstDone", 32'(done_o), 32'd0);
    checkOutput("rstRdata", bus.cfg_rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // basic 2x2 fill
    applyStimulus(8'h0A, 8'h14, 8'h01, 8'h01, 3'd5, 0, 0, 0, -1);
    readReg(REG_CTRL, {30'd0, ovrModel, 1'b0}, "statusAfterFill");

    // CPU store on the 2nd engine cycle
    applyStimulus(8'h0A, 8'h14, 8'h01, 8'h01, 3'd5, 2, 1, 0, -1);

    // wrap in both x and y
    applyStimulus(8'hFE, 8'hFF, 8'h02, 8'h01, 3'd3, 0, 0, 0, -1);

    // single pixel
    applyStimulus(8'h77, 8'h33, 8'h00, 8'h00, 3'd6, 0, 0, 0, -1);

    // 240x240 aborted after 100 pixels, with CPU traffic
    applyStimulus(8'h05, 8'h07, 8'hEF, 8'hEF, 3'd1, 1, 0, 100, -1);
    readReg(REG_CTRL, {30'd0, ovrModel, 1'b0}, "statusAfterAbort");

    // START while busy sets OVR; ORIGIN rewrite does not disturb the fill
    applyStimulus(8'h40, 8'h50, 8'h03, 8'h02, 3'd4, 0, 0, 0, 2);
    readReg(REG_CTRL, {30'd0, ovrModel, 1'b0}, "statusOvr");
    readReg(REG_ORIGIN, {16'd0, originModel}, "originRewritten");
    cfgWrite(REG_CTRL, 32'd4);
    readReg(REG_CTRL, {30'd0, ovrModel, 1'b0}, "statusOvrCleared");

    cfgWrite(REG_COLOR, 32'hFFFF_FFFF);
    readReg(REG_COLOR, 32'd7, "colorUnusedBits");
    cfgWrite(REG_SIZE, 32'hABCD_1234);
    readReg(REG_SIZE, 32'h0000_1234, "sizeUnusedBits");

    // START together with ABORT while idle starts nothing
    cfgWrite(REG_CTRL, 32'd3);
    checkOutput("idleStartAbortBusy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("idleStartAbortWe", 32'(bus.vmem_we_o), 32'd0);
    checkOutput("idleStartAbortBusy2", 32'(busy_o), 32'd0);

    // reset in the middle of a fill
    cfgWrite(REG_ORIGIN, 32'h0000_2030);
    cfgWrite(REG_SIZE, 32'h0000_0303);
    cfgWrite(REG_COLOR, 32'd6);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_addr_i  = REG_CTRL;
    bus.cfg_wdata_i = 32'd1;
    tick();
    bus.cfg_we_i = 1'b0;
    repeat (5) tick();
    checkOutput("preResetWe", 32'(bus.vmem_we_o), 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("midRstWe", 32'(bus.vmem_we_o), 32'd0);
    checkOutput("midRstAddr", 32'(bus.vmem_addr_o), 32'd0);
    checkOutput("midRstBusy", 32'(busy_o), 32'd0);
    checkOutput("midRstDone", 32'(done_o), 32'd0);
    checkOutput("midRstRdata", bus.cfg_rdata_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    ovrModel    = 1'b0;
    originModel = '0;
    tick();
    checkOutput("postRstBusy", 32'(busy_o), 32'd0);
    checkOutput("postRstWe", 32'(bus.vmem_we_o), 32'd0);
    applyStimulus(8'h20, 8'h30, 8'h03, 8'h03, 3'd6, 0, 0, 0, -1);

    // randomised fills with CPU traffic and occasional overrunning STARTs
    repeat (12) begin
      rx  = 8'($urandom);
      ry  = 8'($urandom);
      rw  = 8'($urandom_range(0, 7));
      rh  = 8'($urandom_range(0, 7));
      rn  = (int'(rw) + 1) * (int'(rh) + 1);
      rms = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rn - 1)) : -1;
      applyStimulus(rx, ry, rw, rh, 3'($urandom), 1, 0, 0, rms);
      readReg(REG_CTRL, {30'd0, ovrModel, 1'b0}, "statusRandom");
      cfgWrite(REG_CTRL, 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vmem_fill_ctrl.md
Name: vmem_fill_ctrl

Overview:
- Hardware rectangle-fill engine and write arbiter for the 3-bit-per-pixel, 256x256-addressed video memory that feeds the ST7789 scan-out.
- Sits between the CPU data bus and the video-memory write port.
- CPU stores pass through with absolute priority. The engine fills the remaining cycles with writes of a constant colour over a programmed rectangle.
- Configured through a small memory-mapped register file. Software polls status or uses the done pulse.

Parameters:
- COORD_W, 8, bits per x/y coordinate; video-memory address is {y, x}, 2*COORD_W bits.
- COLOR_W, 3, pixel width stored in video memory.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- cfg_we_i  in  1  register write strobe
- cfg_addr_i  in  2  register word index
- cfg_wdata_i  in  32  register write data
- cfg_rdata_o  out  32  register read data, registered
- cpu_we_i  in  1  CPU video-memory store
- cpu_addr_i  in  16  CPU pixel address {y, x}
- cpu_wdata_i  in  3  CPU pixel data
- vmem_we_o  out  1  video-memory write enable
- vmem_addr_o  out  16  video-memory write address
- vmem_wdata_o  out  3  video-memory write data
- busy_o  out  1  fill in progress
- done_o  out  1  one-cycle pulse on fill completion

Behaviour:
- Register map (word index):
  - 0 ORIGIN: [7:0] x0, [15:8] y0.
  - 1 SIZE: [7:0] w-1, [15:8] h-1.
  - 2 COLOR: [2:0] colour.
  - 3 CTRL/STATUS:
    - Write: bit0 START, bit1 ABORT, bit2 clears OVR.
    - Read: bit0 busy, bit1 OVR (sticky overrun).
- Unused read bits return 0. cfg_rdata_o is updated every cycle from cfg_addr_i, so read latency is 1 cycle.
- Reset values: all registers 0, OVR 0, state IDLE, busy_o 0, done_o 0, vmem_we_o 0, vmem_addr_o 0, vmem_wdata_o 0, cfg_rdata_o 0.
- Write-port outputs are registered (1-cycle latency). Priority:
  - cpu_we_i=1: next cycle drives the CPU address and data with vmem_we_o=1. The engine stalls and its counters hold.
  - Else, state RUN: next cycle drives engine {y, x} and the colour with vmem_we_o=1.
  - Else: vmem_we_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - CTRL write with START=1: latch ORIGIN, SIZE and COLOR into working copies, set x=x0, y=y0, column count=0, row count=0, then go to RUN.
  - busy_o goes high in the cycle after the CTRL write.
- RUN:
  - Each non-stalled cycle issues one pixel.
  - Column count reaches w-1: x reloads to x0, y increments, column count clears, row count increments. Otherwise x and column count increment.
  - x and y wrap modulo 256 independently. There is no clipping to the 240-pixel panel.
  - Issuing pixel (w-1, h-1) goes to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
- Total fill time is w*h plus the number of CPU-store cycles, from first issue to last issue.
- Register writes while busy update the programmable registers only. The running fill uses its latched copies.
- START while busy (RUN or DONE): ignored, OVR set to 1.
- ABORT while RUN: IDLE on the next cycle. No done pulse; pixels already issued remain.
- START and ABORT set together:
  - In IDLE: ABORT wins, nothing starts.
  - In RUN: abort, and OVR is set.
- OVR clear and an overrunning START in the same cycle: set wins.
- Reset mid-fill: immediate return to IDLE with all outputs at reset values. A write is not guaranteed to complete if reset is asserted in its output cycle.

Decomposition:
- Shared package vmem_fill_pkg:
  - register index constants REG_ORIGIN/REG_SIZE/REG_COLOR/REG_CTRL
  - CTRL bit positions
  - FSM state encoding
  - COORD_W/COLOR_W defaults
- One sub-module, fill_rect_walker: x/y and column/row counters with a load and advance interface and a last-pixel flag.
- The FSM, arbiter mux and register file stay in vmem_fill_ctrl.

Test Plan:
1. ORIGIN=0x140A, SIZE=0x0101, COLOR=5, START -> vmem writes 0x140A, 0x140B, 0x150A, 0x150B with data 5 on 4 consecutive cycles; done_o pulses once on the following cycle; busy_o reads 0 afterwards.
2. Same fill with cpu_we_i=1 (addr 0x0000, data 2) on the 2nd engine cycle -> that cycle outputs 0x0000/2; the engine sequence resumes unchanged; 5 write cycles total.
3. ORIGIN=0xFFFE, SIZE=0x0102, START -> addresses FFFE, FFFF, FF00, 00FE, 00FF, 0000 (wrap in both x and y).
4. SIZE=0xEFEF (240x240) fill; write ABORT after 100 pixels -> exactly 100 engine writes, no done_o, busy_o=0 on the next read.
5. START while busy -> working fill unchanged; STATUS reads 0x3 (busy, OVR); after CTRL write bit2 -> OVR reads 0.
6. Assert rst_i mid-fill for 1 cycle -> vmem_we_o=0, busy_o=0 immediately; a subsequent START performs a complete fill.
